// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction-fetch stage.
//   fetch_state_e : fetch controller states (IDLE, REQ, ERR)
//   INST_W        : instruction / address width
//   PC_STEP       : PC increment for a completed fetch
//   pcAligned()   : true when the low PC bits address a word boundary
// ---------------------------------------------------------------------------
package fetch_pkg;

  localparam int INST_W = 32;
  localparam logic [INST_W-1:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ERR  = 2'd2
  } fetch_state_e;

  // Only the two low bits matter for word alignment.
  function automatic logic pcAligned(input logic [1:0] pcLow);
    return (pcLow == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_timeout_counter.sv
// ---------------------------------------------------------------------------
// fetch_timeout_counter
// Counts consecutive unacknowledged instruction-memory request cycles.
//   clk     in  : clock, rising edge
//   rstd    in  : synchronous active-high reset
//   inc     in  : a request was outstanding and not acknowledged this cycle
//   clr     in  : restart the wait (ack, redirect or backpressure)
//   expired out : the count reaches TIMEOUT_CYCLES at the coming edge
// ---------------------------------------------------------------------------
module fetch_timeout_counter
  import fetch_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic clk,
  input  logic rstd,
  input  logic inc,
  input  logic clr,
  output logic expired
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES);

  logic [7:0] count_q;
  logic [7:0] count_d;

  // Next count: clearing wins over counting, and the count saturates at
  // the limit so it cannot wrap back to zero while the stage is stuck.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != LIMIT)) begin
      count_d = count_q + 8'd1;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rstd) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Looking at the next value makes the error land exactly one edge after
  // the TIMEOUT_CYCLES-th unacknowledged request cycle.
  assign expired = (count_d == LIMIT);

endmodule

// File: rtl/inst_fetch.sv
// ---------------------------------------------------------------------------
// inst_fetch
// Instruction-fetch stage between the PC register and decode. Requests the
// word at pc, buffers the returned word with its PC under valid/ready, and
// returns the PC register's next value every cycle.
//   clk             in  : clock, rising edge
//   rstd            in  : synchronous active-high reset
//   pc              in  : current PC from the PC register
//   nextpc          out : next PC (pc on stall, pc+4 on fetch, target on redirect)
//   imem_req        out : instruction-memory read request
//   imem_addr       out : read address (always pc)
//   imem_ack        in  : read complete, meaningful while imem_req is high
//   imem_rdata      in  : instruction word returned with imem_ack
//   redirect_valid  in  : taken branch / jump from a later stage
//   redirect_target in  : redirect PC
//   inst_valid      out : buffered instruction available to decode
//   inst_ready      in  : decode accepts the buffered instruction
//   inst_data       out : buffered instruction word
//   inst_pc         out : PC of inst_data
//   fetch_error     out : sticky misalignment / timeout error
// ---------------------------------------------------------------------------
module inst_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic              clk,
  input  logic              rstd,
  input  logic [INST_W-1:0] pc,
  output logic [INST_W-1:0] nextpc,
  output logic              imem_req,
  output logic [INST_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [INST_W-1:0] redirect_target,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_data,
  output logic [INST_W-1:0] inst_pc,
  output logic              fetch_error
);

  fetch_state_e state_q;
  fetch_state_e state_d;

  logic              instValid_q;
  logic              instValid_d;
  logic [INST_W-1:0] instData_q;
  logic [INST_W-1:0] instData_d;
  logic [INST_W-1:0] instPc_q;
  logic [INST_W-1:0] instPc_d;

  logic fetching;
  logic canLoad;
  logic aligned;
  logic fetchFire;
  logic flush;
  logic waitInc;
  logic waitClr;
  logic timeoutHit;

  // Requests are also held off while rstd is high so the memory never sees
  // a request during the reset cycle itself.
  assign fetching  = (state_q == REQ) && !rstd;
  assign canLoad   = !instValid_q || inst_ready;
  assign aligned   = pcAligned(pc[1:0]);
  assign imem_req  = fetching && canLoad && !redirect_valid && aligned;
  assign imem_addr = pc;
  assign fetchFire = imem_req && imem_ack;
  assign flush     = redirect_valid && (state_q != ERR);

  assign waitInc = imem_req && !imem_ack;
  assign waitClr = imem_ack || redirect_valid || !canLoad;

  fetch_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rstd   (rstd),
    .inc    (waitInc),
    .clr    (waitClr),
    .expired(timeoutHit)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rstd) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Controller: one settling cycle after reset, then fetch until a
  // misaligned PC or a timeout parks the stage in ERR until reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (!aligned || timeoutHit) begin
          state_d = ERR;
        end
      end
      ERR:     state_d = ERR;
      default: state_d = IDLE;
    endcase
  end

  // Next PC: the PC register loads every clock, so holding means echoing pc.
  // A redirect wins over a same-cycle ack, dropping that fetched word.
  always_comb begin
    nextpc = pc;
    if (fetching) begin
      if (redirect_valid) begin
        nextpc = redirect_target;
      end else if (fetchFire) begin
        nextpc = pc + PC_STEP;
      end
    end
  end

  // Decode buffer: a flush beats a load, and a load beats a plain drain,
  // so accept-and-load in one cycle keeps the buffer valid with the new word.
  always_comb begin
    instValid_d = instValid_q;
    instData_d  = instData_q;
    instPc_d    = instPc_q;
    if (flush) begin
      instValid_d = 1'b0;
    end else if (fetchFire) begin
      instValid_d = 1'b1;
      instData_d  = imem_rdata;
      instPc_d    = pc;
    end else if (inst_ready) begin
      instValid_d = 1'b0;
    end
  end

  // Buffer registers.
  always_ff @(posedge clk) begin
    if (rstd) begin
      instValid_q <= 1'b0;
      instData_q  <= '0;
      instPc_q    <= '0;
    end else begin
      instValid_q <= instValid_d;
      instData_q  <= instData_d;
      instPc_q    <= instPc_d;
    end
  end

  assign inst_valid  = instValid_q;
  assign inst_data   = instData_q;
  assign inst_pc     = instPc_q;
  assign fetch_error = (state_q == ERR);

endmodule

// File: tb/tb_inst_fetch.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch
// Drives inst_fetch with directed scenarios followed by random traffic, with
// the PC register looped back from nextpc, and compares every cycle against a
// behavioural model of the fetch stage.
// ---------------------------------------------------------------------------
module tb_inst_fetch;

  localparam int TIMEOUT = 15;
  localparam logic [31:0] XOR_KEY = 32'hA5A50000;

  logic        clk = 1'b0;
  logic        rstd;
  logic [31:0] pc;
  logic [31:0] nextpc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        fetch_error;

  int total = 0;
  int bad   = 0;

  // Behavioural model: has the stage left its post-reset cycle, is it in
  // error, what the decode buffer holds, and how many unacknowledged
  // requests have happened in a row.
  bit          mStarted;
  bit          mErr;
  bit          mValid;
  logic [31:0] mData;
  logic [31:0] mPc;
  int          mWait;

  // Values observed in the most recent cycle, for directed checks.
  logic        snapReq;
  logic        snapValid;
  logic        snapErr;
  logic [31:0] snapAddr;
  logic [31:0] snapNext;
  logic [31:0] snapData;
  logic [31:0] snapInstPc;

  logic [31:0] stallPc;
  logic [31:0] errPc;
  int          reqCount;

  always #5 clk = ~clk;

  inst_fetch #(
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk            (clk),
    .rstd           (rstd),
    .pc             (pc),
    .nextpc         (nextpc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .fetch_error    (fetch_error)
  );

  // Single comparison point: counts it and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, predict and compare outputs, advance the
  // model across the edge, then load the PC register from nextpc.
  task automatic applyStimulus(input bit r, input bit a, input bit rdy, input bit rv,
                               input logic [31:0] tgt);
    bit          active;
    bit          canLoad;
    bit          expReq;
    bit          fire;
    logic [31:0] expNext;
    logic [31:0] pcNow;
    rstd            = r;
    imem_ack        = a;
    inst_ready      = rdy;
    redirect_valid  = rv;
    redirect_target = tgt;
    imem_rdata      = a ? (pc ^ XOR_KEY) : $urandom();
    #2;
    pcNow   = pc;
    active  = mStarted && !mErr && !r;
    canLoad = !mValid || rdy;
    expReq  = active && canLoad && !rv && (pcNow[1:0] == 2'b00);
    fire    = expReq && a;
    if (!active)   expNext = pcNow;
    else if (rv)   expNext = tgt;
    else if (fire) expNext = pcNow + 32'd4;
    else           expNext = pcNow;

    snapReq    = imem_req;
    snapValid  = inst_valid;
    snapErr    = fetch_error;
    snapAddr   = imem_addr;
    snapNext   = nextpc;
    snapData   = inst_data;
    snapInstPc = inst_pc;

    checkOutput("imem_req",    32'(imem_req),    32'(expReq));
    checkOutput("imem_addr",   imem_addr,        pcNow);
    checkOutput("nextpc",      nextpc,           expNext);
    checkOutput("inst_valid",  32'(inst_valid),  32'(mValid));
    checkOutput("inst_data",   inst_data,        mData);
    checkOutput("inst_pc",     inst_pc,          mPc);
    checkOutput("fetch_error", 32'(fetch_error), 32'(mErr));

    if (r) begin
      mStarted = 0;
      mErr     = 0;
      mValid   = 0;
      mData    = '0;
      mPc      = '0;
      mWait    = 0;
    end else begin
      if (rv && !mErr) begin
        mValid = 0;
      end else if (fire) begin
        mValid = 1;
        mData  = pcNow ^ XOR_KEY;
        mPc    = pcNow;
      end else if (rdy) begin
        mValid = 0;
      end
      if (active) begin
        if (pcNow[1:0] != 2'b00) begin
          mErr = 1;
        end else begin
          mWait = (expReq && !a) ? mWait + 1 : 0;
          if (mWait >= TIMEOUT) mErr = 1;
        end
      end
      mStarted = 1;
    end

    @(posedge clk);
    #1;
    pc = snapNext;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] tgt;
    bit          doRst;
    pc = '0; rstd = 1'b1; imem_ack = 1'b0; inst_ready = 1'b0;
    redirect_valid = 1'b0; redirect_target = '0; imem_rdata = '0;
    mStarted = 0; mErr = 0; mValid = 0; mData = '0; mPc = '0; mWait = 0;
    @(posedge clk);
    #1;

    // Reset, then zero-wait memory with decode always ready.
    applyStimulus(1, 0, 1, 0, 0);
    applyStimulus(1, 0, 1, 0, 0);
    checkOutput("rstValid", 32'(snapValid), 0);
    checkOutput("rstErr", 32'(snapErr), 0);
    pc = '0;
    applyStimulus(0, 1, 1, 0, 0);
    checkOutput("idleReq", 32'(snapReq), 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1, 1, 0, 0);
      checkOutput("seqAddr", snapAddr, 32'(i * 4));
      if (i > 0) begin
        checkOutput("seqPc", snapInstPc, 32'((i - 1) * 4));
        checkOutput("seqData", snapData, 32'((i - 1) * 4) ^ XOR_KEY);
      end
    end

    // Decode stall for 5 cycles, then release.
    stallPc = pc;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 1, 0, 0, 0);
      checkOutput("stallReq", 32'(snapReq), 0);
      checkOutput("stallNext", snapNext, stallPc);
      checkOutput("stallData", snapData, 32'h0000000C ^ XOR_KEY);
    end
    applyStimulus(0, 1, 1, 0, 0);
    checkOutput("resumeAddr", snapAddr, 32'h10);
    checkOutput("resumeReq", 32'(snapReq), 1);

    // Redirect coinciding with a late ack.
    pc = 32'h8;
    applyStimulus(0, 0, 1, 0, 0);
    applyStimulus(0, 1, 1, 1, 32'h100);
    checkOutput("redirNext", snapNext, 32'h100);
    applyStimulus(0, 1, 1, 0, 0);
    checkOutput("redirFlush", 32'(snapValid), 0);
    checkOutput("redirAddr", snapAddr, 32'h100);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("redirLoadPc", snapInstPc, 32'h100);

    // Memory never acknowledges: timeout.
    reqCount = 0;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(0, 0, 1, 0, 0);
      if (snapErr) break;
      if (snapReq) reqCount++;
    end
    checkOutput("toReqCycles", 32'(reqCount), 32'(TIMEOUT));
    checkOutput("toErr", 32'(snapErr), 1);
    errPc = pc;
    applyStimulus(0, 1, 1, 1, 32'h200);
    checkOutput("errReq", 32'(snapReq), 0);
    checkOutput("errIgnoreRedir", snapNext, errPc);
    applyStimulus(0, 1, 1, 0, 0);
    checkOutput("errHoldAddr", snapAddr, errPc);
    checkOutput("errSticky", 32'(snapErr), 1);

    // Redirect to a misaligned target.
    applyStimulus(1, 0, 1, 0, 0);
    applyStimulus(0, 0, 1, 0, 0);
    applyStimulus(0, 0, 1, 1, 32'h102);
    checkOutput("misNext", snapNext, 32'h102);
    applyStimulus(0, 1, 1, 0, 0);
    checkOutput("misReq", 32'(snapReq), 0);
    applyStimulus(0, 1, 1, 0, 0);
    checkOutput("misErr", 32'(snapErr), 1);

    // PC wrap at the top of the address space.
    applyStimulus(1, 0, 1, 0, 0);
    pc = 32'hFFFFFFFC;
    applyStimulus(0, 0, 1, 0, 0);
    applyStimulus(0, 1, 1, 0, 0);
    checkOutput("wrapNext", snapNext, 32'h0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("wrapInstPc", snapInstPc, 32'hFFFFFFFC);
    checkOutput("wrapAddr", snapAddr, 32'h0);

    // Reset with a buffered word and an outstanding request.
    applyStimulus(0, 1, 1, 0, 0);
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("preRstValid", 32'(snapValid), 1);
    checkOutput("preRstReq", 32'(snapReq), 1);
    applyStimulus(1, 0, 1, 0, 0);
    checkOutput("inRstReq", 32'(snapReq), 0);
    applyStimulus(0, 1, 1, 0, 0);
    checkOutput("postRstValid", 32'(snapValid), 0);
    checkOutput("postRstData", snapData, 0);
    checkOutput("postRstPc", snapInstPc, 0);
    checkOutput("postRstReq", 32'(snapReq), 0);
    applyStimulus(0, 1, 1, 0, 0);
    checkOutput("firstReq", 32'(snapReq), 1);

    // Random traffic with occasional resets and misaligned redirects.
    for (int i = 0; i < 600; i++) begin
      doRst = (i % 90 == 0) || (mErr && ($urandom_range(0, 3) == 0));
      tgt = $urandom_range(0, 1023) << 2;
      if ($urandom_range(0, 19) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
      applyStimulus(doRst, $urandom_range(0, 9) < 7, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 9) == 0, tgt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
